// File: rtl/s_sub_lanes.sv
// s_sub_lanes: multi-cycle AES SubBytes engine.
// Substitutes LANES bytes per clock over a BLOCK_BYTES state, with a
// ready/enable handshake on both sides so the round controller can stall it.
// Optional feature macro: S_SUB_INV_EN adds inverse S-box lanes so that
// inv = 1 selects InvSubBytes; without it the engine is forward-only and
// the inv input is ignored.
module s_sub_lanes #(
  parameter int BLOCK_BYTES = 16,
  parameter int LANES       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [8*BLOCK_BYTES-1:0] data_in,
  input  logic                     inv,
  input  logic                     i_en,
  output logic                     i_rdy,
  output logic [8*BLOCK_BYTES-1:0] data_out,
  output logic                     o_en,
  input  logic                     o_rdy,
  output logic                     busy
);

  localparam int W  = 8 * BLOCK_BYTES;
  localparam int N  = BLOCK_BYTES / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, SUB, HOLD} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    work_q, work_d;
  logic [W-1:0]    dout_q, dout_d;
  logic [W-1:0]    subbed;
  logic [7:0]      laneOut [LANES];
  logic            capture;
  logic            lastStep;

  // GF(2^8) multiply modulo the AES polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254, which also maps 0 to 0
  function automatic logic [7:0] gfInv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    logic [7:0] e;
    r = 8'h01;
    p = x;
    e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gfMul(r, p);
      p = gfMul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  // Forward S-box: field inverse followed by the affine transform
  function automatic logic [7:0] sboxFwd(input logic [7:0] x);
    logic [7:0] b;
    logic [7:0] r1, r2, r3, r4;
    b  = gfInv(x);
    r1 = rotl1(b);
    r2 = rotl1(r1);
    r3 = rotl1(r2);
    r4 = rotl1(r3);
    return b ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
  endfunction

`ifdef S_SUB_INV_EN
  logic mode_q, mode_d;

  // Inverse S-box: inverse affine transform followed by the field inverse
  function automatic logic [7:0] sboxInv(input logic [7:0] x);
    logic [7:0] r1, r3, r6;
    r1 = rotl1(x);
    r3 = rotl1(rotl1(r1));
    r6 = rotl1(rotl1(rotl1(r3)));
    return gfInv(r1 ^ r3 ^ r6 ^ 8'h05);
  endfunction
`else
  logic unusedInv;
  assign unusedInv = inv;
`endif

  // One forward (and optionally inverse) lookup per lane on the active byte group
  for (genvar l = 0; l < LANES; l++) begin : gLane
    logic [7:0] laneIn;
    assign laneIn = work_q[8*(int'(cnt_q)*LANES + l) +: 8];
`ifdef S_SUB_INV_EN
    assign laneOut[l] = mode_q ? sboxInv(laneIn) : sboxFwd(laneIn);
`else
    assign laneOut[l] = sboxFwd(laneIn);
`endif
  end

  assign capture  = i_en & i_rdy;
  assign lastStep = (cnt_q == CW'(N - 1));
  assign data_out = dout_q;

  // Merge this cycle's substituted lanes back into the work register image
  always_comb begin
    subbed = work_q;
    for (int l = 0; l < LANES; l++) begin
      subbed[8*(int'(cnt_q)*LANES + l) +: 8] = laneOut[l];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: capture, N substitution steps, then hold for the consumer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_en) state_d = SUB;
      SUB:     if (lastStep) state_d = HOLD;
      HOLD:    if (o_rdy) state_d = i_en ? SUB : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state
  always_comb begin
    i_rdy = (state_q == IDLE) | ((state_q == HOLD) & o_rdy);
    o_en  = (state_q == HOLD);
    busy  = (state_q == SUB);
  end

  // Datapath next values: load on capture, substitute in SUB, publish on the last step
  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
`ifdef S_SUB_INV_EN
    mode_d = mode_q;
`endif
    if (capture) begin
      work_d = data_in;
      cnt_d  = '0;
`ifdef S_SUB_INV_EN
      mode_d = inv;
`endif
    end else if (state_q == SUB) begin
      work_d = subbed;
      cnt_d  = lastStep ? '0 : cnt_q + 1'b1;
      if (lastStep) dout_d = subbed;
    end
  end

  // Datapath registers, cleared asynchronously so a reset drops any in-flight block
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work_q <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
`ifdef S_SUB_INV_EN
      mode_q <= 1'b0;
`endif
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
`ifdef S_SUB_INV_EN
      mode_q <= mode_d;
`endif
    end
  end

endmodule
